rng_reader: RTL and testbench

Consumer-side front end for the `rng` block: drives the generator's `en`, captures each word `rng` presents with `ready`, and buffers captured words in a small show-ahead FIFO. Runs a repetition-count health test on the raw stream. Serves buffered words to downstream logic over a valid/ready handshake. Sits between `rng` and every in-chip consumer of random words.

---
 rtl/rng_reader.sv | 141 ++++++++++++++
 tb/tb_rng_reader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rng_reader.sv
// rng_reader: consumer-side front end for the rng generator.
// Requests words from rng, runs a repetition-count health test on every
// captured word, buffers passing words in a show-ahead FIFO and serves them
// downstream over a valid/ready handshake.
//
// Handshakes: a transfer happens on a rising edge where the source's valid
// (rng_en && rng_ready upstream, out_valid downstream) and the sink's ready
// are both high; valid never depends combinationally on ready.
module rng_reader #(
  parameter int WORDSIZE  = 8,
  parameter int DEPTH     = 4,
  parameter int REP_LIMIT = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  output logic                rng_en,
  input  logic [WORDSIZE-1:0] rng_data,
  input  logic                rng_ready,
  output logic [WORDSIZE-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                rep_fail,
  input  logic                clr_fail,
  output logic [15:0]         word_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = $clog2(REP_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [RW-1:0] REP_TRIP  = RW'(REP_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FAIL = 2'd2
  } state_t;

  // state is left as a plain named signal so checkers can bind to it.
  state_t              state;
  logic [WORDSIZE-1:0] mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic [RW-1:0]       rep_cnt;
  logic [WORDSIZE-1:0] prev_word;
  logic                prev_valid;

  logic                capture;
  logic                push;
  logic                pop;
  logic                trip;
  logic [RW-1:0]       rep_next;

  // Outputs decoded from registers only.
  assign rng_en    = (state == RUN) && (count < FULL_CNT);
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  // Health-test evaluation of the word being captured this cycle.
  always_comb begin
    capture  = rng_en && rng_ready;
    rep_next = RW'(1);
    if (prev_valid && (rng_data == prev_word)) begin
      rep_next = RW'(rep_cnt + 1'b1);
    end
    trip = capture && (rep_next == REP_TRIP);
    push = capture && !trip;
    pop  = out_valid && out_ready;
  end

  // FSM, FIFO pointers, health-test state and delivery counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rep_cnt    <= '0;
      prev_word  <= '0;
      prev_valid <= 1'b0;
      rep_fail   <= 1'b0;
      word_cnt   <= '0;
    end else begin
      // A pop is completed and counted even on the edge that trips FAIL.
      if (pop) begin
        word_cnt <= word_cnt + 16'd1;
      end

      if (capture) begin
        rep_cnt    <= rep_next;
        prev_word  <= rng_data;
        prev_valid <= 1'b1;
      end

      if (trip) begin
        // Failing word is dropped and everything buffered is discarded.
        state    <= FAIL;
        rep_fail <= 1'b1;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        if (push) begin
          wr_ptr <= PW'((32'(wr_ptr) + 1) % DEPTH);
        end
        if (pop) begin
          rd_ptr <= PW'((32'(rd_ptr) + 1) % DEPTH);
        end
        if (push && !pop) begin
          count <= count + 1'b1;
        end else if (pop && !push) begin
          count <= count - 1'b1;
        end

        unique case (state)
          IDLE: if (en) state <= RUN;
          RUN:  if (!en) state <= IDLE;
          FAIL: begin
            if (clr_fail) begin
              state      <= IDLE;
              rep_fail   <= 1'b0;
              rep_cnt    <= '0;
              prev_valid <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // FIFO storage; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem[wr_ptr] <= rng_data;
    end
  end

endmodule

// File: tb/tb_rng_reader.sv
// Testbench for rng_reader: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based behavioural model.
module tb_rng_reader;

  localparam int W         = 8;
  localparam int DEPTH     = 4;
  localparam int REP_LIMIT = 3;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic         rng_en;
  logic [W-1:0] rng_data = '0;
  logic         rng_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         rep_fail;
  logic         clr_fail = 1'b0;
  logic [15:0]  word_cnt;

  always #5 clk = ~clk;

  rng_reader #(.WORDSIZE(W), .DEPTH(DEPTH), .REP_LIMIT(REP_LIMIT)) dut (
    .clk(clk), .reset(reset), .en(en), .rng_en(rng_en),
    .rng_data(rng_data), .rng_ready(rng_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .rep_fail(rep_fail), .clr_fail(clr_fail), .word_cnt(word_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Mode follows the three operating modes described for the block:
  // 0 = idle, 1 = running, 2 = failed.
  logic [W-1:0] exp_q[$];
  int           m_mode = 0;
  int           m_rep = 0;
  logic [W-1:0] m_prev = '0;
  bit           m_prev_v = 0;
  bit           m_fail = 0;
  logic [15:0]  m_wcnt = '0;
  bit           m_known = 0;

  always @(posedge clk) begin
    if (!reset) begin
      exp_q.delete();
      m_mode = 0; m_rep = 0; m_prev_v = 0; m_fail = 0; m_wcnt = '0;
      m_known = 1;
    end else if (m_known) begin
      bit req, take, got, tripped;
      int rn;
      req     = (m_mode == 1) && (exp_q.size() < DEPTH);
      take    = (exp_q.size() != 0) && out_ready;
      got     = req && rng_ready;
      tripped = 0;
      if (take) begin
        void'(exp_q.pop_front());
        m_wcnt = m_wcnt + 16'd1;
      end
      if (got) begin
        rn = (m_prev_v && rng_data == m_prev) ? m_rep + 1 : 1;
        m_rep = rn; m_prev = rng_data; m_prev_v = 1;
        if (rn == REP_LIMIT) begin
          tripped = 1;
          exp_q.delete();
          m_mode = 2;
          m_fail = 1;
        end else begin
          exp_q.push_back(rng_data);
        end
      end
      if (!tripped) begin
        if (m_mode == 0 && en) m_mode = 1;
        else if (m_mode == 1 && !en) m_mode = 0;
        else if (m_mode == 2 && clr_fail) begin
          m_mode = 0; m_fail = 0; m_rep = 0; m_prev_v = 0;
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (m_known) begin
      check("rng_en", {31'd0, rng_en}, {31'd0, (m_mode == 1) && (exp_q.size() < DEPTH)});
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) check("out_data", {24'd0, out_data}, {24'd0, exp_q[0]});
      check("rep_fail", {31'd0, rep_fail}, {31'd0, m_fail});
      check("word_cnt", {16'd0, word_cnt}, {16'd0, m_wcnt});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b0; en = 1'b0; rng_ready = 1'b0; out_ready = 1'b0; clr_fail = 1'b0;
    ticks(2);
    reset = 1'b1;
  endtask

  task automatic drain();
    rng_ready = 1'b0; out_ready = 1'b1;
    ticks(DEPTH + 1);
    out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] seq;
    int guard;
    do_reset();
    check("lit_reset_rng_en", {31'd0, rng_en}, 32'd0);
    check("lit_reset_valid", {31'd0, out_valid}, 32'd0);
    check("lit_reset_wcnt", {16'd0, word_cnt}, 32'd0);

    // Three captures with no consumer.
    en = 1'b1; rng_ready = 1'b1; rng_data = 8'h11;
    tick();
    check("lit_rng_en_run", {31'd0, rng_en}, 32'd1);
    tick();
    check("lit_first_valid", {31'd0, out_valid}, 32'd1);
    check("lit_first_data", {24'd0, out_data}, 32'h11);
    rng_data = 8'h22; tick();
    rng_data = 8'h33; tick();
    check("lit_head_kept", {24'd0, out_data}, 32'h11);
    drain();
    check("lit_wcnt3", {16'd0, word_cnt}, 32'd3);

    // Fill to full, then drain in order.
    rng_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      rng_data = W'(i); tick();
    end
    check("lit_full_rng_en", {31'd0, rng_en}, 32'd0);
    rng_ready = 1'b0; out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("lit_drain_order", {24'd0, out_data}, i);
      tick();
    end
    out_ready = 1'b0;
    check("lit_wcnt7", {16'd0, word_cnt}, 32'd7);
    check("lit_empty", {31'd0, out_valid}, 32'd0);

    // Continuous streaming across pointer wrap.
    rng_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rng_data = 8'h40 + W'(i); tick();
    end
    out_ready = 1'b1;
    for (int i = 4; i < 20; i++) begin
      rng_data = 8'h40 + W'(i); tick();
    end
    drain();

    // Repetition failure and recovery.
    rng_ready = 1'b1; rng_data = 8'h5A;
    ticks(3);
    check("lit_rep_fail", {31'd0, rep_fail}, 32'd1);
    check("lit_fail_valid", {31'd0, out_valid}, 32'd0);
    check("lit_fail_rng_en", {31'd0, rng_en}, 32'd0);
    clr_fail = 1'b1; tick(); clr_fail = 1'b0;
    check("lit_clr", {31'd0, rep_fail}, 32'd0);
    tick();
    rng_data = 8'h5A; ticks(2);
    rng_data = 8'h3C; tick();
    rng_data = 8'h5A; tick();
    check("lit_no_fail", {31'd0, rep_fail}, 32'd0);
    drain();

    // Reset while words are buffered.
    rng_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rng_data = 8'h70 + W'(i); tick();
    end
    reset = 1'b0; tick(); reset = 1'b1;
    check("lit_rst_valid", {31'd0, out_valid}, 32'd0);
    check("lit_rst_rng_en", {31'd0, rng_en}, 32'd0);
    check("lit_rst_wcnt", {16'd0, word_cnt}, 32'd0);

    // word_cnt wrap: stream non-repeating data with consumer always ready.
    en = 1'b1; rng_ready = 1'b1; out_ready = 1'b1; seq = 16'd0;
    guard = 0;
    while (m_wcnt != 16'hFFFF && guard < 70000) begin
      rng_data = seq[7:0]; seq = seq + 16'd1; tick(); guard++;
    end
    check("lit_wcnt_max", {16'd0, word_cnt}, 32'h0000FFFF);
    guard = 0;
    while (m_wcnt != 16'h0000 && guard < 8) begin
      rng_data = seq[7:0]; seq = seq + 16'd1; tick(); guard++;
    end
    check("lit_wcnt_wrap", {16'd0, word_cnt}, 32'd0);
    drain();

    // Randomized traffic with narrow data to exercise the health test.
    for (int i = 0; i < 3000; i++) begin
      en        = ($urandom_range(0, 9) != 0);
      rng_ready = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 2) != 0);
      rng_data  = W'($urandom_range(0, 3));
      clr_fail  = ($urandom_range(0, 7) == 0);
      reset     = ($urandom_range(0, 199) != 0);
      tick();
    end
    reset = 1'b1; clr_fail = 1'b0;
    ticks(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
